// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode stage.
//   - datapath / register-address widths
//   - major opcode constants
//   - ALU operation and immediate-format enums
//   - the per-instruction control bundle produced by the decoder
//   - alu_decode(): funct3/funct7 -> ALU operation
package decode_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e   alu_op;
    imm_type_e imm_type;
    logic      src_imm;
    logic      src_pc;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      branch;
    logic      jal;
    logic      jalr;
    logic      illegal;
    logic      uses_rs1;
    logic      uses_rs2;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops (ADDI has no
  // SUBI form); for shifts-right it selects arithmetic in both formats.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                         input logic       funct7_b5,
                                         input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr    in  instruction bits [31:7] (opcode bits carry no immediate)
//   imm_type in  immediate format selected by the decoder
//   imm      out sign-extended 32-bit immediate (0 for IMM_NONE)
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode between the IF/ID latch and EX.
//   clk, rst_n            pipeline clock, async active-low reset
//   id_valid/instr/pc     IF/ID slot contents
//   flush                 EX redirect; kills what would enter ID/EX
//   stall_o               hold PC and IF/ID (load-use hazard)
//   rf_raddr1/2           register file read addresses (combinational)
//   rf_rdata1/2           register file read data
//   wb_we/waddr/wdata     writeback port, bypassed into the operands
//   ex_*                  registered ID/EX pipeline contents
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = DATA_WIDTH,
  parameter int RADDR_W = REG_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic [XLEN-1:0]    id_pc,
  input  logic               flush,
  output logic               stall_o,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]    wb_wdata,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]    ex_imm,
  output logic [3:0]         ex_alu_op,
  output logic               ex_alu_src_imm,
  output logic               ex_alu_src_pc,
  output logic [2:0]         ex_funct3,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_branch,
  output logic               ex_jal,
  output logic               ex_jalr,
  output logic               ex_illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7_b5;
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [RADDR_W-1:0] rd;

  assign opcode    = id_instr[6:0];
  assign funct3    = id_instr[14:12];
  assign funct7_b5 = id_instr[30];
  assign rs1       = id_instr[19:15];
  assign rs2       = id_instr[24:20];
  assign rd        = id_instr[11:7];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // ---------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------
  ctrl_t ctrl;

  always_comb begin
    ctrl.alu_op    = ALU_ADD;
    ctrl.imm_type  = IMM_NONE;
    ctrl.src_imm   = 1'b0;
    ctrl.src_pc    = 1'b0;
    ctrl.mem_read  = 1'b0;
    ctrl.mem_write = 1'b0;
    ctrl.reg_write = 1'b0;
    ctrl.branch    = 1'b0;
    ctrl.jal       = 1'b0;
    ctrl.jalr      = 1'b0;
    ctrl.illegal   = 1'b0;
    ctrl.uses_rs1  = 1'b0;
    ctrl.uses_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op    = alu_decode(funct3, funct7_b5, 1'b1);
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.uses_rs2  = 1'b1;
      end
      OP_IMM: begin
        ctrl.alu_op    = alu_decode(funct3, funct7_b5, 1'b0);
        ctrl.imm_type  = IMM_I;
        ctrl.src_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        ctrl.imm_type  = IMM_I;
        ctrl.src_imm   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        ctrl.imm_type  = IMM_S;
        ctrl.src_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.uses_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        // ALU compares rs1 against rs2; the target adder uses the imm.
        ctrl.alu_op   = ALU_SUB;
        ctrl.imm_type = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.imm_type  = IMM_J;
        ctrl.src_imm   = 1'b1;
        ctrl.src_pc    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
      end
      OP_JALR: begin
        ctrl.imm_type  = IMM_I;
        ctrl.src_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.uses_rs1  = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.imm_type  = IMM_U;
        ctrl.src_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.imm_type  = IMM_U;
        ctrl.src_imm   = 1'b1;
        ctrl.src_pc    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  logic [31:0] imm;

  imm_gen u_imm_gen (
    .instr    (id_instr[31:7]),
    .imm_type (ctrl.imm_type),
    .imm      (imm)
  );

  // ---------------------------------------------------------------
  // WB->ID bypass and load-use detection, one lane per source port.
  // The bypass covers a register file that writes on the same edge
  // this stage samples, so the read data would otherwise be stale.
  // ---------------------------------------------------------------
  logic [RADDR_W-1:0] rs_idx   [2];
  logic [XLEN-1:0]    rd_raw   [2];
  logic [XLEN-1:0]    op_data  [2];
  logic [1:0]         uses_rs;
  logic [1:0]         rs_hit;
  logic               load_use;

  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;
  assign rd_raw[0] = rf_rdata1;
  assign rd_raw[1] = rf_rdata2;
  assign uses_rs   = {ctrl.uses_rs2, ctrl.uses_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign op_data[gi] = (wb_we && (wb_waddr != '0) && (wb_waddr == rs_idx[gi]))
                           ? wb_wdata : rd_raw[gi];
      // Fields an instruction does not read must never create a stall.
      assign rs_hit[gi]  = uses_rs[gi] && (ex_rd == rs_idx[gi]);
    end
  endgenerate

  // ex_rd is already zero unless the EX instruction writes a register.
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (|rs_hit);

  // A flush discards the waiting instruction, so holding IF/ID is moot.
  assign stall_o = load_use && !flush;

  // ---------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_imm         <= '0;
      ex_alu_op      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_alu_src_pc  <= 1'b0;
      ex_funct3      <= '0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jal         <= 1'b0;
      ex_jalr        <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (flush || load_use) begin
      // Bubble: only side-effecting controls are cleared; datapath
      // fields are left as they are since nothing consumes them.
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs1_data    <= op_data[0];
      ex_rs2_data    <= op_data[1];
      ex_rs1         <= rs1;
      ex_rs2         <= rs2;
      ex_rd          <= ctrl.reg_write ? rd : '0;
      ex_imm         <= imm;
      ex_alu_op      <= ctrl.alu_op;
      ex_alu_src_imm <= ctrl.src_imm;
      ex_alu_src_pc  <= ctrl.src_pc;
      ex_funct3      <= funct3;
      ex_mem_read    <= ctrl.mem_read;
      ex_mem_write   <= ctrl.mem_write;
      ex_reg_write   <= ctrl.reg_write;
      ex_branch      <= ctrl.branch;
      ex_jal         <= ctrl.jal;
      ex_jalr        <= ctrl.jalr;
      ex_illegal     <= ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized
// instruction streams, checked by a scoreboard fed from a reference model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_alu_src_pc;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jal, ex_jalr, ex_illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .flush(flush), .stall_o(stall_o),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_alu_src_pc(ex_alu_src_pc), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        uses1, uses2, rw, mr, mw, br, jal, jalr, ill, src_imm, src_pc, has_imm;
    logic [3:0]  alu;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic        chk_ctrl, chk_full, valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        has_imm, ill_dp;
    logic        src_imm, src_pc;
    logic [2:0]  f3;
    logic [6:0]  ctl;  // {mr, mw, rw, br, jal, jalr, ill}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn = 0;

  // Model of what sits in EX, as far as hazard detection cares.
  logic       m_valid = 1'b0, m_mr = 1'b0;
  logic [4:0] m_rd = '0;
  logic       last_stall = 1'b0;

  // Per-step stimulus knobs.
  logic        k_valid, k_flush, k_we;
  logic [4:0]  k_waddr;
  logic [31:0] k_wdata, k_r1, k_r2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic knobs_default();
    k_valid = 1'b1; k_flush = 1'b0; k_we = 1'b0; k_waddr = '0;
    k_wdata = '0; k_r1 = 32'h1111_0000; k_r2 = 32'h2222_0000;
  endtask

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_e o;
    case (f3)
      3'd0: o = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'd1: o = ALU_SLL;
      3'd2: o = ALU_SLT;
      3'd3: o = ALU_SLTU;
      3'd4: o = ALU_XOR;
      3'd5: o = alt ? ALU_SRA : ALU_SRL;
      3'd6: o = ALU_OR;
      default: o = ALU_AND;
    endcase
    return o;
  endfunction

  // Reference decode written from the ISA rules; immediates via arithmetic shifts.
  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] hi, sg;
    d = '0;
    s = ins;
    sg = s >>> 31;
    d.alu = ALU_ADD;
    case (ins[6:0])
      7'h33: begin d.uses1 = 1; d.uses2 = 1; d.rw = 1; d.alu = alu_of(ins[14:12], ins[30], 1'b1); end
      7'h13: begin d.uses1 = 1; d.rw = 1; d.src_imm = 1; d.has_imm = 1;
                   hi = s >>> 20; d.imm = hi; d.alu = alu_of(ins[14:12], ins[30], 1'b0); end
      7'h03: begin d.uses1 = 1; d.rw = 1; d.mr = 1; d.src_imm = 1; d.has_imm = 1;
                   hi = s >>> 20; d.imm = hi; end
      7'h23: begin d.uses1 = 1; d.uses2 = 1; d.mw = 1; d.src_imm = 1; d.has_imm = 1;
                   hi = s >>> 25; d.imm = (hi << 5) | 32'(ins[11:7]); end
      7'h63: begin d.uses1 = 1; d.uses2 = 1; d.br = 1; d.has_imm = 1; d.alu = ALU_SUB;
                   d.imm = (sg << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
      7'h6F: begin d.rw = 1; d.jal = 1; d.src_imm = 1; d.src_pc = 1; d.has_imm = 1;
                   d.imm = (sg << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
      7'h67: begin d.uses1 = 1; d.rw = 1; d.jalr = 1; d.src_imm = 1; d.has_imm = 1;
                   hi = s >>> 20; d.imm = hi; end
      7'h37: begin d.rw = 1; d.src_imm = 1; d.has_imm = 1; d.alu = ALU_PASS_B; d.imm = ins & 32'hFFFF_F000; end
      7'h17: begin d.rw = 1; d.src_imm = 1; d.src_pc = 1; d.has_imm = 1; d.imm = ins & 32'hFFFF_F000; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // Present one instruction for one cycle, check the combinational outputs
  // and queue the expected ID/EX contents for the monitor.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    exp_t e;
    logic hz;
    logic [4:0] rs1, rs2, rd;
    @(negedge clk);
    id_instr = ins; id_pc = pc; id_valid = k_valid; flush = k_flush;
    wb_we = k_we; wb_waddr = k_waddr; wb_wdata = k_wdata;
    rf_rdata1 = k_r1; rf_rdata2 = k_r2;
    #1;
    d   = model_decode(ins);
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    hz  = k_valid && m_valid && m_mr && (m_rd != 0) &&
          ((d.uses1 && m_rd == rs1) || (d.uses2 && m_rd == rs2));
    last_stall = hz && !k_flush;
    chk("stall_o", 32'(stall_o), 32'(last_stall));
    chk("rf_raddr1", 32'(rf_raddr1), 32'(rs1));
    chk("rf_raddr2", 32'(rf_raddr2), 32'(rs2));
    e = '0;
    if (k_flush || hz) begin
      e.chk_ctrl = 1'b1;
      m_valid = 1'b0; m_mr = 1'b0; m_rd = '0;
    end else begin
      e.valid    = k_valid;
      e.chk_ctrl = k_valid;
      e.chk_full = k_valid;
      e.pc       = pc;
      e.rs1d     = (k_we && k_waddr != 0 && k_waddr == rs1) ? k_wdata : k_r1;
      e.rs2d     = (k_we && k_waddr != 0 && k_waddr == rs2) ? k_wdata : k_r2;
      e.rs1      = rs1;
      e.rs2      = rs2;
      e.rd       = d.rw ? rd : 5'd0;
      e.imm      = d.imm;
      e.has_imm  = d.has_imm;
      e.ill_dp   = d.ill;
      e.alu      = d.alu;
      e.src_imm  = d.src_imm;
      e.src_pc   = d.src_pc;
      e.f3       = ins[14:12];
      e.ctl      = {d.mr, d.mw, d.rw, d.br, d.jal, d.jalr, d.ill};
      m_valid = k_valid; m_mr = d.mr; m_rd = e.rd;
    end
    sb.push_back(e);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the ID/EX register presents one slot.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d: ex_valid=%b pc=%h rd=%0d alu=%0d ctl=%b", n_txn, ex_valid, ex_pc, ex_rd, ex_alu_op,
                 {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jal, ex_jalr, ex_illegal});
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        if (e.chk_ctrl) begin
          chk("ex_ctl", 32'({ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jal, ex_jalr, ex_illegal}),
              32'(e.ctl));
          chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        end
        if (e.chk_full) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rs1_data", ex_rs1_data, e.rs1d);
          chk("ex_rs2_data", ex_rs2_data, e.rs2d);
          chk("ex_rs_idx", 32'({ex_rs1, ex_rs2}), 32'({e.rs1, e.rs2}));
          chk("ex_funct3", 32'(ex_funct3), 32'(e.f3));
          if (e.has_imm) chk("ex_imm", ex_imm, e.imm);
          if (!e.ill_dp) begin
            chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
            chk("ex_alu_src", 32'({ex_alu_src_imm, ex_alu_src_pc}), 32'({e.src_imm, e.src_pc}));
          end
        end
      end
    end
  end

  // Reset-state comparison of every ID/EX output plus stall_o.
  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctl"}, 32'({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jal,
                            ex_jalr, ex_illegal, ex_alu_src_imm, ex_alu_src_pc, stall_o}), 32'd0);
    chk({tag, "_idx"}, 32'({ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_funct3}), 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_imm"}, ex_imm, 32'd0);
    chk({tag, "_ops"}, ex_rs1_data | ex_rs2_data, 32'd0);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, pc;
    logic        hold;
    int          sel;
    knobs_default();
    id_valid = 1'b1;
    id_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03);
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Bypass from WB, then with x0 as the WB target (no bypass).
    k_r1 = 32'h11; k_r2 = 32'h11; k_we = 1'b1; k_waddr = 5'd3; k_wdata = 32'hABCD;
    step(enc_r(5'd3, 5'd3, 5'd4), 32'h100);
    post_edge();
    chk("bypass_rs1", ex_rs1_data, 32'hABCD);
    chk("bypass_rs2", ex_rs2_data, 32'hABCD);
    k_waddr = 5'd0;
    step(enc_r(5'd3, 5'd3, 5'd4), 32'h104);
    post_edge();
    chk("nobypass_x0", ex_rs1_data, 32'h11);
    knobs_default();

    // LW x5 then ADD x6,x5,x2: one-cycle stall, bubble, then issue.
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 32'h108);
    step(enc_r(5'd2, 5'd5, 5'd6), 32'h10C);
    chk("lduse_stall", 32'(stall_o), 32'd1);
    post_edge();
    chk("lduse_bubble", 32'(ex_valid), 32'd0);
    step(enc_r(5'd2, 5'd5, 5'd6), 32'h10C);
    chk("lduse_release", 32'(stall_o), 32'd0);

    // SW uses x5 only as rs2 and still stalls.
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 32'h110);
    step(enc_sw(12'd0, 5'd5, 5'd2), 32'h114);
    chk("sw_rs2_stall", 32'(stall_o), 32'd1);
    step(enc_sw(12'd0, 5'd5, 5'd2), 32'h114);

    // LUI has no source register, so no stall after LW x7.
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'h03), 32'h118);
    step({20'h12345, 5'd7, 7'h37}, 32'h11C);
    chk("lui_nostall", 32'(stall_o), 32'd0);

    // Flush beats a pending hazard.
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 32'h120);
    k_flush = 1'b1;
    step(enc_r(5'd2, 5'd5, 5'd6), 32'h124);
    chk("flush_nostall", 32'(stall_o), 32'd0);
    post_edge();
    chk("flush_kill", 32'({ex_valid, ex_reg_write}), 32'd0);
    knobs_default();

    // Immediates: beq x0,x0,-4; jal x0,+4; sw with offset -1.
    step(32'hFE00_0EE3, 32'h200);
    post_edge();
    chk("imm_b_neg", ex_imm, 32'hFFFF_FFFC);
    step(32'h0040_006F, 32'h204);
    post_edge();
    chk("imm_j", ex_imm, 32'd4);
    step(enc_sw(12'hFFF, 5'd3, 5'd2), 32'h208);
    post_edge();
    chk("imm_s_m1", ex_imm, 32'hFFFF_FFFF);

    // Illegal opcode and x0 destination handling.
    step(32'h0000_03FF, 32'h20C);
    post_edge();
    chk("illegal", 32'({ex_valid, ex_illegal, ex_reg_write}), 32'b110);
    step(enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'h13), 32'h210);
    post_edge();
    chk("addi_x0_rd", 32'(ex_rd), 32'd0);
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'h03), 32'h214);
    step(enc_r(5'd0, 5'd0, 5'd6), 32'h218);
    chk("x0_nostall", 32'(stall_o), 32'd0);

    // Reset while a load-use stall is being signalled.
    step(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 32'h300);
    @(negedge clk);
    id_instr = enc_r(5'd2, 5'd5, 5'd6); id_valid = 1'b1; flush = 1'b0;
    #1;
    chk("pre_reset_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midstall_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_mr = 1'b0; m_rd = '0;
    step(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), 32'h400);
    post_edge();
    chk("addi_after_reset", 32'({ex_valid, ex_alu_op, ex_rd}), 32'({1'b1, 4'(ALU_ADD), 5'd1}));
    chk("addi_imm", ex_imm, 32'd5);

    // Random stream; a stalled instruction is re-presented as IF/ID would.
    hold = 1'b0;
    ins = '0; pc = '0;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        ins = $urandom();
        sel = $urandom_range(0, 9);
        case (sel)
          0: ins[6:0] = 7'h33;
          1: ins[6:0] = 7'h13;
          2: ins[6:0] = 7'h03;
          3: ins[6:0] = 7'h23;
          4: ins[6:0] = 7'h63;
          5: ins[6:0] = 7'h6F;
          6: ins[6:0] = 7'h67;
          7: ins[6:0] = 7'h37;
          8: ins[6:0] = 7'h17;
          default: ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0F : 7'h7F;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        pc = $urandom() & 32'hFFFF_FFFC;
        k_valid = ($urandom_range(0, 7) != 0);
      end
      k_flush = ($urandom_range(0, 9) == 0);
      k_we    = 1'($urandom_range(0, 1));
      k_waddr = 5'($urandom_range(0, 7));
      k_wdata = $urandom();
      k_r1    = $urandom();
      k_r2    = $urandom();
      step(ins, pc);
      hold = last_stall;
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
